// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle datapath controller.
// MULTICYCLE_CONTROL_ADDI_EN adds the addi states and makes opcode 001000 legal.
package mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned COUNT_W  = 16;

`ifdef MULTICYCLE_CONTROL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_START     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        ,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
`endif
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic [1:0]         pc_source;
        logic               ior_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (ADDI_EN && (op == OP_ADDI));
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore state-to-control decode; only FETCH looks at memory ready for IR/PC load.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = 2'b01;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: o_ctrl.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.ior_d     = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = 2'b10;
            end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDI_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: o_ctrl.reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with retired-instruction counter.
// Define MULTICYCLE_CONTROL_ADDI_EN to support addi (opcode 001000).
module multicycle_control
    import mc_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                memReady,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic [1:0]          pcSource,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memToReg,
    output logic                regDst,
    output logic                regWrite,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                illegalOp,
    output logic [STATE_W-1:0]  state,
    output logic [COUNT_W-1:0]  instrCount
);

    state_t               r_state;
    state_t               w_next_state;
    logic [COUNT_W-1:0]   r_instr_count;
    ctrl_t                w_ctrl;
    logic                 w_retire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_START;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_START:  w_next_state = S_FETCH;
            S_FETCH:  if (memReady) w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
                    OP_ADDI:      w_next_state = S_ADDI_EXEC;
`endif
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (memReady) w_next_state = S_MEM_WB;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: if (memReady) w_next_state = S_FETCH;
            S_EXECUTE:   w_next_state = S_R_WB;
            S_R_WB:      w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDI_EXEC: w_next_state = S_ADDI_WB;
            S_ADDI_WB:   w_next_state = S_FETCH;
`endif
            default:     w_next_state = S_START;
        endcase
    end

    mc_output_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (memReady),
        .o_ctrl      (w_ctrl)
    );

    // Last cycle of each instruction; a store only finishes once memory accepts it.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
            S_MEM_WRITE:                        w_retire = memReady;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDI_WB:                          w_retire = 1'b1;
`endif
            default:                            w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_instr_count <= '0;
        else if (w_retire) r_instr_count <= r_instr_count + COUNT_W'(1);
    end

    assign pcWrite     = w_ctrl.pc_write;
    assign pcWriteCond = w_ctrl.pc_write_cond;
    assign pcSource    = w_ctrl.pc_source;
    assign iorD        = w_ctrl.ior_d;
    assign memRead     = w_ctrl.mem_read;
    assign memWrite    = w_ctrl.mem_write;
    assign irWrite     = w_ctrl.ir_write;
    assign memToReg    = w_ctrl.mem_to_reg;
    assign regDst      = w_ctrl.reg_dst;
    assign regWrite    = w_ctrl.reg_write;
    assign aluSrcA     = w_ctrl.alu_src_a;
    assign aluSrcB     = w_ctrl.alu_src_b;
    assign aluOp       = w_ctrl.alu_op;
    assign illegalOp   = (r_state == S_DECODE) && !is_supported(opcode);
    assign state       = r_state;
    assign instrCount  = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic        memReady;
    logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic        memToReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0]  pcSource, aluSrcB, aluOp;
    logic [3:0]  state;
    logic [15:0] instrCount;

    typedef struct {
        int          id;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_step   = 0;
    logic [15:0] exp_cnt  = 16'h0000;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .memReady    (memReady),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .pcSource    (pcSource),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .illegalOp   (illegalOp),
        .state       (state),
        .instrCount  (instrCount)
    );

    // Control table written out state by state from the requirements.
    function automatic logic [16:0] exp_ctrl(input state_t st, input logic mr, input logic ill);
        logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] ps, asb, aop;
        {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
        ps = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            S_FETCH:     begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:    asb = 2'b11;
            S_MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; end
            S_MEM_READ:  begin mrd = 1'b1; iord = 1'b1; end
            S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
            S_MEM_WRITE: begin mwr = 1'b1; iord = 1'b1; end
            S_EXECUTE:   begin asa = 1'b1; aop = 2'b10; end
            S_R_WB:      begin rw = 1'b1; rdst = 1'b1; end
            S_BRANCH:    begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; end
            S_JUMP:      begin pw = 1'b1; ps = 2'b10; end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDI_EXEC: begin asa = 1'b1; asb = 2'b10; end
            S_ADDI_WB:   rw = 1'b1;
`endif
            default: ;
        endcase
        return {pw, pwc, ps, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, ill};
    endfunction

    function automatic logic retires(input state_t st, input logic mr);
        case (st)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: return 1'b1;
            S_MEM_WRITE: return mr;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDI_WB: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Called just after a rising edge: drive inputs, queue the expectation for this cycle.
    task automatic step(input logic [5:0] op, input logic mr, input state_t st, input logic ill);
        exp_t e;
        opcode   = op;
        memReady = mr;
        n_step++;
        e.id   = n_step;
        e.st   = 4'(st);
        e.ctrl = exp_ctrl(st, mr, ill);
        e.cnt  = exp_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (reset_n && retires(st, mr)) exp_cnt = exp_cnt + 16'd1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [16:0] act;
            e   = sb_q.pop_front();
            act = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
                   memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, illegalOp};
            n_checks++;
            if (state === e.st && act === e.ctrl && instrCount === e.cnt)
                n_pass++;
            else
                $display("FAIL step%0d: got state=%0d ctrl=%05h cnt=%04h, expected state=%0d ctrl=%05h cnt=%04h",
                         e.id, state, act, instrCount, e.st, e.ctrl, e.cnt);
        end
    end

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    initial begin
        reset_n  = 1'b0;
        opcode   = 6'd0;
        memReady = 1'b0;
        @(posedge clk);
        #1;
        // Reset held, then released: START for one cycle, then FETCH.
        step(RT, 1'b1, S_START, 1'b0);
        step(RT, 1'b1, S_START, 1'b0);
        reset_n = 1'b1;
        step(LW, 1'b1, S_START, 1'b0);
        // lw, memory always ready: 5 cycles.
        step(LW, 1'b1, S_FETCH, 1'b0);
        step(LW, 1'b1, S_DECODE, 1'b0);
        step(LW, 1'b1, S_MEM_ADDR, 1'b0);
        step(LW, 1'b1, S_MEM_READ, 1'b0);
        step(LW, 1'b1, S_MEM_WB, 1'b0);
        // sw with three wait cycles in MEM_WRITE.
        step(SW, 1'b1, S_FETCH, 1'b0);
        step(SW, 1'b1, S_DECODE, 1'b0);
        step(SW, 1'b1, S_MEM_ADDR, 1'b0);
        step(SW, 1'b0, S_MEM_WRITE, 1'b0);
        step(SW, 1'b0, S_MEM_WRITE, 1'b0);
        step(SW, 1'b0, S_MEM_WRITE, 1'b0);
        step(SW, 1'b1, S_MEM_WRITE, 1'b0);
        // R-type, beq (memReady low where it is ignored), j: 10 cycles.
        step(RT, 1'b1, S_FETCH, 1'b0);
        step(RT, 1'b1, S_DECODE, 1'b0);
        step(RT, 1'b1, S_EXECUTE, 1'b0);
        step(RT, 1'b1, S_R_WB, 1'b0);
        step(BEQ, 1'b1, S_FETCH, 1'b0);
        step(BEQ, 1'b0, S_DECODE, 1'b0);
        step(BEQ, 1'b0, S_BRANCH, 1'b0);
        step(JMP, 1'b1, S_FETCH, 1'b0);
        step(JMP, 1'b1, S_DECODE, 1'b0);
        step(JMP, 1'b1, S_JUMP, 1'b0);
        // Fetch wait then an illegal opcode: one-cycle pulse, no retire.
        step(BAD, 1'b0, S_FETCH, 1'b0);
        step(BAD, 1'b1, S_FETCH, 1'b0);
        step(BAD, 1'b1, S_DECODE, 1'b1);
        // lw aborted by reset during a MEM_READ wait.
        step(LW, 1'b1, S_FETCH, 1'b0);
        step(LW, 1'b1, S_DECODE, 1'b0);
        step(LW, 1'b1, S_MEM_ADDR, 1'b0);
        step(LW, 1'b0, S_MEM_READ, 1'b0);
        step(LW, 1'b0, S_MEM_READ, 1'b0);
        reset_n = 1'b0;
        exp_cnt = 16'h0000;
        step(LW, 1'b1, S_START, 1'b0);
        reset_n = 1'b1;
        step(LW, 1'b1, S_START, 1'b0);
        // addi: legal only with the optional feature built in.
        step(ADDI, 1'b1, S_FETCH, 1'b0);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        step(ADDI, 1'b1, S_DECODE, 1'b0);
        step(ADDI, 1'b1, S_ADDI_EXEC, 1'b0);
        step(ADDI, 1'b1, S_ADDI_WB, 1'b0);
`else
        step(ADDI, 1'b1, S_DECODE, 1'b1);
`endif
        // Counter preloaded just below wrap; two jumps roll it over to zero.
        force dut.r_instr_count = 16'hFFFE;
        #1;
        release dut.r_instr_count;
        exp_cnt = 16'hFFFE;
        step(JMP, 1'b1, S_FETCH, 1'b0);
        step(JMP, 1'b1, S_DECODE, 1'b0);
        step(JMP, 1'b1, S_JUMP, 1'b0);
        step(JMP, 1'b1, S_FETCH, 1'b0);
        step(JMP, 1'b1, S_DECODE, 1'b0);
        step(JMP, 1'b1, S_JUMP, 1'b0);
        step(JMP, 1'b0, S_FETCH, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 Port list (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- opcode  in  6  instr[31:26], valid from DECODE onward
- memReady  in  1  memory access completes this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero
- pcSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- iorD  out  1  memory address: 0 PC, 1 ALUOut
- memRead, memWrite  out  1 each  memory strobes
- irWrite  out  1  instruction register load
- memToReg  out  1  writeback data: 1 MDR, 0 ALUOut
- regDst  out  1  dest: 1 rd, 0 rt
- regWrite  out  1  register file write
- aluSrcA  out  1  0 PC, 1 regA
- aluSrcB  out  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
- aluOp  out  2  to ALU control: 00 add, 01 sub, 10 R-type funct
- illegalOp  out  1  one-cycle pulse, unsupported opcode
- state  out  4  current state (debug)
- instrCount  out  16  retired instruction count

Function
REQ-003 Moore FSM states: START, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP (+ ADDI_EXEC, ADDI_WB per REQ-014).
REQ-004 Transitions: START->FETCH; FETCH->DECODE when memReady, else hold; DECODE by opcode: 100011/101011->MEM_ADDR, 000000->EXECUTE, 000100->BRANCH, 000010->JUMP, other->FETCH.
REQ-005 MEM_ADDR->MEM_READ (lw) or MEM_WRITE (sw); MEM_READ->MEM_WB when memReady, else hold; MEM_WRITE->FETCH when memReady, else hold; MEM_WB, R_WB, BRANCH, JUMP, EXECUTE->R_WB all unconditional to next.
REQ-006 Outputs decoded from state only, except irWrite/pcWrite in FETCH; every output not listed for a state is 0.
- START: all 0
- FETCH: memRead=1, aluSrcB=01, irWrite=pcWrite=memReady
- DECODE: aluSrcB=11
- MEM_ADDR: aluSrcA=1, aluSrcB=10
- MEM_READ: memRead=1, iorD=1
- MEM_WB: regWrite=1, memToReg=1
- MEM_WRITE: memWrite=1, iorD=1
- EXECUTE: aluSrcA=1, aluOp=10
- R_WB: regWrite=1, regDst=1
- BRANCH: aluSrcA=1, aluOp=01, pcWriteCond=1, pcSource=01
- JUMP: pcWrite=1, pcSource=10
REQ-007 Latency with memReady constantly 1: lw 5, sw 4, R-type 4, beq 3, j 3 cycles FETCH-to-FETCH; each cycle memReady=0 in FETCH/MEM_READ/MEM_WRITE adds one cycle.
REQ-008 illegalOp SHALL pulse 1 for exactly the DECODE cycle of an unsupported opcode; the instruction is not retired.
REQ-009 instrCount SHALL increment by 1 on the last cycle of each instruction (MEM_WB, MEM_WRITE with memReady, R_WB, BRANCH, JUMP, ADDI_WB) and wrap 0xFFFF->0x0000.
REQ-010 memReady outside FETCH/MEM_READ/MEM_WRITE SHALL be ignored.

Reset
REQ-011 reset_n low SHALL asynchronously force state=START, instrCount=0, hence all control outputs 0, illegalOp=0.
REQ-012 Reset asserted mid-instruction (including mid memory wait) SHALL abort it without retiring; first FETCH occurs one cycle after reset_n deasserts.

Configuration
REQ-013 Macro MULTICYCLE_CONTROL_ADDI_EN selects addi support.
REQ-014 Defined: opcode 001000 DECODE->ADDI_EXEC (aluSrcA=1, aluSrcB=10, aluOp=00)->ADDI_WB (regWrite=1, regDst=0, memToReg=0)->FETCH, 4 cycles. Undefined: 001000 is illegal per REQ-008; ADDI states absent.

Structure
REQ-015 Shared package mc_pkg SHALL hold the state encoding, opcode constants (LW, SW, RTYPE, BEQ, J, ADDI) and aluOp constants (ADD=00, SUB=01, FUNCT=10).
REQ-016 The state-to-control decode SHALL be a combinational sub-module mc_output_decode; state register and counter stay in the top.

Verification
REQ-017 Reset, then lw (100011), memReady=1 -> states START,FETCH,DECODE,MEM_ADDR,MEM_READ,MEM_WB; regWrite=memToReg=1 in MEM_WB; instrCount=1.
REQ-018 sw with memReady low 3 cycles in MEM_WRITE -> memWrite=1 held 4 cycles, single retire, back to FETCH.
REQ-019 R-type then beq then j -> aluOp 10, 01, then pcWrite=1 with pcSource=10; instrCount=3 after 10 cycles.
REQ-020 opcode 111111 -> illegalOp pulses one cycle, next state FETCH, instrCount unchanged.
REQ-021 reset_n low during MEM_READ wait -> outputs 0 immediately, instrCount=0, FETCH one cycle after release.
REQ-022 Preload near wrap: 65536 retired instructions -> instrCount returns to 0x0000; addi retires in 4 cycles only with MULTICYCLE_CONTROL_ADDI_EN defined, illegalOp otherwise.
